// File: rtl/apb_ic_pkg.sv
// ----------------------------------------------------------------------------
// apb_ic_pkg
// Shared definitions for the APB slave interconnect and the memory-port
// round-robin arbiter (apb_rr_arbiter).
//   arb_state_t  : arbiter FSM states
//   ADDR_W_DEF   : default address width
//   DATA_W_DEF   : default data width
//   DEPTH_ADDR   : number of addressable words behind the shared memory port,
//                  also used by the slave interconnect for its decode limit
// ----------------------------------------------------------------------------
package apb_ic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_ADDR = 1024;

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// apb_rr_arbiter_if
// Bundles the requester channels and the downstream memory port of the
// round-robin arbiter.
//   req_valid/req_write/req_addr/req_wdata : per-channel commands (flattened,
//                                            channel i at [i*W +: W])
//   req_ack/resp_rdata/resp_err            : completion returned to channels
//   mem_req/mem_write/mem_addr/mem_wdata   : command to the memory port
//   mem_ready/mem_rdata                    : memory completion
// Modports:
//   master : the arbiter's view (drives acks and the memory command)
//   slave  : the environment's view (requesters plus memory)
// ----------------------------------------------------------------------------
interface apb_rr_arbiter_if
    import apb_ic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]         resp_rdata;
    logic                      resp_err;

    logic                      mem_req;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_ready;
    logic [DATA_W-1:0]         mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ack, resp_rdata, resp_err, mem_req, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ack, resp_rdata, resp_err, mem_req, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/apb_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotate-priority picker. Searches req starting at
// last_grant+1 and wrapping modulo NUM_REQ (NUM_REQ need not be a power of
// two); the channel at last_grant is therefore searched last.
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    most recently granted channel
//   any_valid  out 1        at least one request present
//   grant_idx  out IDX_W    selected channel (0 when any_valid is low)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the lowest-priority offset to the highest so that the
    // nearest requester after last_grant is the last one to overwrite.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// apb_rr_arbiter
// Round-robin arbiter sharing one memory port between NUM_REQ request
// channels. One command is granted at a time, driven to the memory port until
// mem_ready, then acknowledged to its channel with a one-cycle req_ack pulse
// carrying read data (zero for writes).
//   PCLK    in  clock
//   PRESET  in  asynchronous active-low reset
//   bus     apb_rr_arbiter_if.master (requester channels + memory port)
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : a BUSY cycle counter aborts a command after TIMEOUT_CYCLES
//               cycles without mem_ready, acknowledging it with resp_err = 1.
//   Undefined : BUSY waits indefinitely and resp_err is tied to 0.
// ----------------------------------------------------------------------------
module apb_rr_arbiter
    import apb_ic_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_rr_arbiter_if.master     bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Elaboration-time sanity check on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_rr_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .any_valid  (pick_valid),
        .grant_idx  (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    assign bus.resp_err = err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    // Single-process FSM. Every output is a register: the memory command is
    // loaded on grant and cleared on completion, and the ack/data pair lives
    // only in RESP. mem_write doubles as the latched direction of the
    // in-flight command, so it is still valid on the completing BUSY edge.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state          <= IDLE;
            last_grant     <= IDX_W'(NUM_REQ - 1);
            grant_idx      <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.req_ack    <= '0;
            bus.resp_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx     <= pick_idx;
                        last_grant    <= pick_idx;
                        bus.mem_req   <= 1'b1;
                        bus.mem_write <= bus.req_write[pick_idx];
                        bus.mem_addr  <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
                        bus.mem_wdata <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                        state         <= BUSY;
                    end
                end

                BUSY: begin
                    if (bus.mem_ready) begin
                        bus.req_ack    <= NUM_REQ'(1) << grant_idx;
                        bus.resp_rdata <= bus.mem_write ? '0 : bus.mem_rdata;
                        bus.mem_req    <= 1'b0;
                        bus.mem_write  <= 1'b0;
                        bus.mem_addr   <= '0;
                        bus.mem_wdata  <= '0;
                        state          <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    // mem_ready is tested first so it wins on the terminal count.
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.req_ack    <= NUM_REQ'(1) << grant_idx;
                        bus.resp_rdata <= '0;
                        err_q          <= 1'b1;
                        bus.mem_req    <= 1'b0;
                        bus.mem_write  <= 1'b0;
                        bus.mem_addr   <= '0;
                        bus.mem_wdata  <= '0;
                        state          <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    bus.req_ack    <= '0;
                    bus.resp_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
                    err_q          <= 1'b0;
`endif
                    state          <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_rr_arbiter
// Directed self-checking bench for apb_rr_arbiter (NUM_REQ = 4, 32-bit
// address/data, TIMEOUT_CYCLES = 8). Inputs change and outputs are sampled on
// the falling edge of PCLK. The timeout scenarios run only when
// ARB_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_apb_rr_arbiter;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b0;
    int   checks = 0;
    int   errors = 0;

    apb_rr_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_rr_arbiter #(
        .NUM_REQ        (4),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    // Absolute guard so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic set_ch(input int ch, input logic v, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[ch]        = v;
        bus.req_write[ch]        = w;
        bus.req_addr[ch*32 +: 32]  = a;
        bus.req_wdata[ch*32 +: 32] = d;
    endtask

    // Waits (bounded) for the next falling edge at which mem_req is high.
    task automatic wait_grant(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.mem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        PRESET        = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", bus.mem_req);
        end
        checks++;
        if (bus.req_ack !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_req_ack: got %b expected 0000", bus.req_ack);
        end
        checks++;
        if ({bus.resp_err, bus.resp_rdata} !== 33'h0) begin
            errors++; $display("[TB] FAIL reset_resp: got %h expected 0", {bus.resp_err, bus.resp_rdata});
        end
        checks++;
        if ({bus.mem_write, bus.mem_addr, bus.mem_wdata} !== 65'h0) begin
            errors++; $display("[TB] FAIL reset_mem_cmd: got %h expected 0", {bus.mem_write, bus.mem_addr, bus.mem_wdata});
        end
        PRESET = 1'b1;
        tick();
    endtask

    task automatic test_stray_ready();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0123;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        tick();
        checks++;
        if ({bus.mem_req, bus.req_ack} !== 5'b0) begin
            errors++; $display("[TB] FAIL stray_ready: got %b expected 00000", {bus.mem_req, bus.req_ack});
        end
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        bit seen;
        for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 1'b0, 32'h100 + c*4, 32'h0);
        for (int k = 0; k < 6; k++) begin
            wait_grant(seen);
            checks++;
            if (!seen || bus.mem_addr !== 32'(32'h100 + exp_order[k]*4)) begin
                errors++; $display("[TB] FAIL rr_grant_%0d: got mem_req %b addr %h expected addr %h",
                                   k, bus.mem_req, bus.mem_addr, 32'h100 + exp_order[k]*4);
            end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'hA000_0000 + k;
            tick();
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            checks++;
            if (bus.req_ack !== 4'(1 << exp_order[k]) || bus.resp_rdata !== 32'hA000_0000 + k) begin
                errors++; $display("[TB] FAIL rr_ack_%0d: got ack %b data %h expected ack %b data %h",
                                   k, bus.req_ack, bus.resp_rdata, 4'(1 << exp_order[k]), 32'hA000_0000 + k);
            end
        end
        bus.req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_single_read();
        bit seen;
        set_ch(2, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        wait_grant(seen);
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL read_grant: got no mem_req expected mem_req");
        end
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({bus.mem_req, bus.mem_write, bus.mem_addr} !== {1'b1, 1'b0, 32'h10} || bus.req_ack !== 4'b0) begin
                errors++; $display("[TB] FAIL read_busy_%0d: got req %b wr %b addr %h ack %b expected 1 0 00000010 0000",
                                   c, bus.mem_req, bus.mem_write, bus.mem_addr, bus.req_ack);
            end
            if (c == 4) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        checks++;
        if (bus.req_ack !== 4'b0100 || bus.resp_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL read_ack: got ack %b data %h expected 0100 deadbeef", bus.req_ack, bus.resp_rdata);
        end
        checks++;
        if (bus.mem_req !== 1'b0 || bus.resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL read_resp_side: got req %b err %b expected 0 0", bus.mem_req, bus.resp_err);
        end
        bus.req_valid[2] = 1'b0;
        tick();
        checks++;
        if (bus.req_ack !== 4'b0 || bus.resp_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL read_ack_pulse: got ack %b data %h expected 0000 0", bus.req_ack, bus.resp_rdata);
        end
    endtask

    task automatic test_hold_during_busy();
        bit seen;
        set_ch(1, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
        set_ch(3, 1'b0, 1'b0, 32'h0000_0300, 32'h0);
        wait_grant(seen);
        checks++;
        if (!seen || {bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h40, 32'h1234_5678}) begin
            errors++; $display("[TB] FAIL hold_grant: got wr %b addr %h wdata %h expected 1 00000040 12345678",
                               bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        // ch1 drops its request and ch3 appears with new payload mid-BUSY.
        set_ch(3, 1'b1, 1'b0, 32'h0000_03F0, 32'h0000_CAFE);
        bus.req_valid[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({bus.mem_req, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'h1234_5678}) begin
                errors++; $display("[TB] FAIL hold_stable_%0d: got req %b wr %b addr %h wdata %h expected 1 1 00000040 12345678",
                                   c, bus.mem_req, bus.mem_write, bus.mem_addr, bus.mem_wdata);
            end
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        checks++;
        if (bus.req_ack !== 4'b0010 || bus.resp_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL hold_write_ack: got ack %b data %h expected 0010 0", bus.req_ack, bus.resp_rdata);
        end
        wait_grant(seen);
        checks++;
        if (!seen || {bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {1'b0, 32'h3F0, 32'h0000_CAFE}) begin
            errors++; $display("[TB] FAIL hold_next_grant: got wr %b addr %h wdata %h expected 0 000003f0 0000cafe",
                               bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_55AA;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.req_valid = '0;
        checks++;
        if (bus.req_ack !== 4'b1000 || bus.resp_rdata !== 32'h0000_55AA) begin
            errors++; $display("[TB] FAIL hold_next_ack: got ack %b data %h expected 1000 000055aa", bus.req_ack, bus.resp_rdata);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        set_ch(2, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        set_ch(3, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        wait_grant(seen);
        checks++;
        if (!seen || bus.mem_addr !== 32'h200) begin
            errors++; $display("[TB] FAIL rst_pre_grant: got req %b addr %h expected 1 00000200", bus.mem_req, bus.mem_addr);
        end
        tick();
        #2;
        PRESET = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.req_ack, bus.mem_addr} !== 37'h0) begin
            errors++; $display("[TB] FAIL rst_async_clear: got req %b ack %b addr %h expected all 0",
                               bus.mem_req, bus.req_ack, bus.mem_addr);
        end
        tick();
        PRESET = 1'b1;
        wait_grant(seen);
        checks++;
        if (!seen || bus.mem_addr !== 32'h200) begin
            errors++; $display("[TB] FAIL rst_first_grant: got req %b addr %h expected 1 00000200", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.req_valid = '0;
        checks++;
        if (bus.req_ack !== 4'b0100 || bus.resp_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("[TB] FAIL rst_after_ack: got ack %b data %h expected 0100 0badf00d", bus.req_ack, bus.resp_rdata);
        end
        tick();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        set_ch(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        set_ch(1, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
        bus.mem_rdata = 32'hBAD0_BAD0;
        wait_grant(seen);
        checks++;
        if (!seen || bus.mem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL tmo_grant: got req %b addr %h expected 1 00000000", bus.mem_req, bus.mem_addr);
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (bus.mem_req !== 1'b1 || bus.req_ack !== 4'b0) begin
                errors++; $display("[TB] FAIL tmo_busy_%0d: got req %b ack %b expected 1 0000", c, bus.mem_req, bus.req_ack);
            end
            tick();
        end
        checks++;
        if ({bus.req_ack, bus.resp_err, bus.resp_rdata, bus.mem_req} !== {4'b0001, 1'b1, 32'h0, 1'b0}) begin
            errors++; $display("[TB] FAIL tmo_ack: got ack %b err %b data %h req %b expected 0001 1 0 0",
                               bus.req_ack, bus.resp_err, bus.resp_rdata, bus.mem_req);
        end
        bus.req_valid[0] = 1'b0;
        bus.mem_rdata    = '0;
    endtask

    task automatic test_timeout_boundary();
        bit seen;
        wait_grant(seen);
        checks++;
        if (!seen || bus.mem_addr !== 32'h44) begin
            errors++; $display("[TB] FAIL tmo_next_grant: got req %b addr %h expected 1 00000044", bus.mem_req, bus.mem_addr);
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (bus.mem_req !== 1'b1 || bus.req_ack !== 4'b0) begin
                errors++; $display("[TB] FAIL tmo_edge_busy_%0d: got req %b ack %b expected 1 0000", c, bus.mem_req, bus.req_ack);
            end
            if (c == 8) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h600D_600D;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.req_valid = '0;
        checks++;
        if ({bus.req_ack, bus.resp_err, bus.resp_rdata} !== {4'b0010, 1'b0, 32'h600D_600D}) begin
            errors++; $display("[TB] FAIL tmo_edge_ack: got ack %b err %b data %h expected 0010 0 600d600d",
                               bus.req_ack, bus.resp_err, bus.resp_rdata);
        end
        tick();
        tick();
    endtask
`endif

    initial begin
        $display("[TB] apb_rr_arbiter directed test start");
        test_reset();
        test_stray_ready();
        test_round_robin();
        test_single_read();
        test_hold_during_busy();
        test_reset_mid_busy();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_boundary();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
